big_deserialize: RTL and testbench
==================================

// Module: big_deserialize
// PURPOSE
//  Receive end of the dual-lane fast serial link: recovers 32-bit words from two 1-bit
//  streams (lane1 -> bits[31:16], lane2 -> bits[15:0], 16 bits/lane/word, MSB first).
//  Word framing comes from a sync-word hunt/verify FSM. Delivers one-cycle dataV strobes
//  with parallel data to the readout logic. Used on test stands and in loopback checks.
// PARAMETERS
//  SYNC_WORD   32'hBC5A_3C0F  framing pattern; must be nonzero (assertion in sim)
//  SYNC_COUNT  2              consecutive aligned sync words required to lock (>=1, <=15)
//  DROP_SYNC   1              1: sync words in LOCKED raise sync_seen only, not dataV
// PORTS
//  out_clk    in   1   fast serial bit clock, rising edge samples both lanes
//  reset_n    in   1   asynchronous, active-low reset
//  enable     in   1   0: freeze all state (mirrors serializer clock gating)
//  resync     in   1   1: drop lock, return to HUNT
//  dataIn1    in   1   serial lane 1 (word bits 31:16)
//  dataIn2    in   1   serial lane 2 (word bits 15:0)
//  dataOut    out  32  recovered word, held between strobes
//  dataV      out  1   one-cycle strobe: dataOut valid
//  locked     out  1   1 while FSM in LOCKED
//  sync_seen  out  1   one-cycle strobe: aligned sync word received while LOCKED
// BEHAVIOUR
//  Reset: dataOut=0, dataV=0, locked=0, sync_seen=0, shift regs=0, state=HUNT, bit_cnt=0.
//  Sampling: on each out_clk edge with enable=1 both lane shift regs shift left, new bit
//   into LSB. sh = {sh1, sh2} (32 bits).
//  enable=0: no shift, no count, no state change; dataV/sync_seen forced 0. A boundary
//   pending when enable drops occurs after enable returns, with no bit lost.
//  Boundary: edge at which the 16th bit of a word is sampled (bit_cnt wraps 15->0).
//  HUNT: compare sh to SYNC_WORD every cycle. Match after edge N -> VERIFY with
//   matches=1, and boundaries defined at edges N+16k. No outputs strobe.
//  VERIFY: at each boundary, sh==SYNC_WORD -> matches+1; on reaching SYNC_COUNT -> LOCKED;
//   mismatch -> HUNT, matches=0. SYNC_COUNT=1 goes HUNT -> LOCKED directly.
//  LOCKED: at boundary edge N, on edge N+1: dataOut<=sh, dataV=1 for exactly one cycle
//   (latency 1 out_clk after LSB sampled). If DROP_SYNC and sh==SYNC_WORD: sync_seen=1,
//   dataV=0, dataOut unchanged. locked=1 registered, rising the edge after lock decision.
//  Lock is never lost on data content; only resync, reset_n, or nothing else.
//  resync=1 (enable=1): next edge -> HUNT, locked=0, matches=0; wins over coincident
//   boundary (no dataV, no sync_seen that cycle). Shift regs keep shifting.
//  Reset asserted mid-word: immediate async clear to reset values; partial word discarded.
//  Max word rate: one dataV per 16 out_clk cycles; dataV never asserted back-to-back.
// STRUCTURE
//  Package big_serial_pkg: LANE_W=16, WORD_W=32, DEFAULT_SYNC_WORD, FSM state enum
//   {HUNT, VERIFY, LOCKED}; shared with the serializer bench model.
//  Sub-module deser_lane (LANE_W shift reg with enable, async reset), instantiated twice.
//  Top: bit_cnt (4 bits), matches counter (4 bits), FSM, output registers.
// TESTING
//  1 Reset held, random lanes -> dataOut=0, dataV=0, locked=0, sync_seen=0.
//  2 SYNC,SYNC,32'hDEADBEEF from bit 0 -> locked=1 after 2nd sync; one dataV,
//    dataOut=32'hDEADBEEF one cycle after its LSB edge.
//  3 Five random bits, then SYNC,SYNC,32'h12345678,32'h0000FFFF -> lock at correct phase;
//    two dataV 16 cycles apart, correct values.
//  4 SYNC then 32'hA5A5A5A5 -> returns to HUNT, locked=0, no dataV; later SYNC,SYNC locks.
//  5 Locked, enable low 7 cycles mid-word of 32'hCAFEF00D (serializer paused) ->
//    dataV once with 32'hCAFEF00D, no strobes during enable=0.
//  6 Locked: SYNC word -> sync_seen pulse, no dataV; resync on boundary edge -> no dataV,
//    locked=0 next cycle; reset_n pulse mid-word -> all outputs 0 immediately.

Source files
------------

// File: rtl/big_serial_pkg.sv
`default_nettype none
// ============================================================================
// Module      : big_serial_pkg
// Description : Shared constants and FSM state type for the dual-lane fast
//               serial link (deserializer RTL and serializer bench model).
// Revision    : 1.0  initial release
// ============================================================================
package big_serial_pkg;

    localparam int LANE_W = 16;
    localparam int WORD_W = 32;

    localparam logic [WORD_W-1:0] DEFAULT_SYNC_WORD = 32'hBC5A_3C0F;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/deser_lane.sv
`default_nettype none
// ============================================================================
// Module      : deser_lane
// Description : One serial lane: MSB-first shift register, new bit enters
//               at the LSB on each enabled clock edge.
// Revision    : 1.0  initial release
// ============================================================================
module deser_lane #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_en,
    input  logic         i_bit,
    output logic [W-1:0] o_sh
);

    logic [W-1:0] r_sh;

    // Shift left on every enabled edge; hold while the link is paused
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh <= '0;
        end else if (i_en) begin
            r_sh <= {r_sh[W-2:0], i_bit};
        end
    end

    assign o_sh = r_sh;

endmodule
`default_nettype wire

// File: rtl/big_deserialize.sv
`default_nettype none
// ============================================================================
// Module      : big_deserialize
// Description : Dual-lane serial receiver. Recovers 32-bit words framed by a
//               sync-word hunt/verify/lock FSM and strobes them out.
// Revision    : 1.0  initial release
// ============================================================================
module big_deserialize
    import big_serial_pkg::*;
#(
    parameter logic [WORD_W-1:0] SYNC_WORD  = DEFAULT_SYNC_WORD,
    parameter int                SYNC_COUNT = 2,
    parameter bit                DROP_SYNC  = 1'b1
) (
    input  logic              out_clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              resync,
    input  logic              dataIn1,
    input  logic              dataIn2,
    output logic [WORD_W-1:0] dataOut,
    output logic              dataV,
    output logic              locked,
    output logic              sync_seen
);

    localparam logic [3:0] c_sync_cnt = 4'(SYNC_COUNT);
    localparam logic [3:0] c_cnt_last = 4'(LANE_W - 1);

    // Elaboration-time sanity checks on the framing parameters
    if (SYNC_WORD == '0) begin : g_bad_sync_word
        $error("big_deserialize: SYNC_WORD must be nonzero");
    end
    if (SYNC_COUNT < 1 || SYNC_COUNT > 15) begin : g_bad_sync_count
        $error("big_deserialize: SYNC_COUNT must be in 1..15");
    end

    logic [LANE_W-1:0] w_sh1;
    logic [LANE_W-1:0] w_sh2;
    logic [WORD_W-1:0] w_sh;
    logic              w_sync;

    state_t            r_state;
    state_t            w_state_nx;
    logic [3:0]        r_matches;
    logic [3:0]        w_matches_nx;
    logic [3:0]        r_bit_cnt;
    logic [3:0]        w_bit_cnt_nx;
    // A full word sits in the shift registers and awaits its decision edge
    logic              r_pend;
    logic              w_pend_nx;
    logic              w_dv_nx;
    logic              w_ss_nx;
    logic              w_load;

    logic [WORD_W-1:0] r_data;
    logic              r_dv;
    logic              r_locked;
    logic              r_ss;

    deser_lane #(.W(LANE_W)) u_lane1 (
        .clk   (out_clk),
        .rst_n (reset_n),
        .i_en  (enable),
        .i_bit (dataIn1),
        .o_sh  (w_sh1)
    );

    deser_lane #(.W(LANE_W)) u_lane2 (
        .clk   (out_clk),
        .rst_n (reset_n),
        .i_en  (enable),
        .i_bit (dataIn2),
        .o_sh  (w_sh2)
    );

    assign w_sh   = {w_sh1, w_sh2};
    assign w_sync = (w_sh == SYNC_WORD);

    // FSM state and framing counters
    always_ff @(posedge out_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= HUNT;
            r_matches <= '0;
            r_bit_cnt <= '0;
            r_pend    <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_matches <= w_matches_nx;
            r_bit_cnt <= w_bit_cnt_nx;
            r_pend    <= w_pend_nx;
        end
    end

    // Next-state, framing and strobe decisions; the word completed at a
    // boundary edge is judged on the following edge from the registered sh
    always_comb begin
        w_state_nx   = r_state;
        w_matches_nx = r_matches;
        w_bit_cnt_nx = r_bit_cnt;
        w_pend_nx    = r_pend;
        w_dv_nx      = 1'b0;
        w_ss_nx      = 1'b0;
        w_load       = 1'b0;
        if (enable) begin
            w_bit_cnt_nx = r_bit_cnt + 4'd1;
            if (resync) begin
                w_state_nx   = HUNT;
                w_matches_nx = '0;
                w_pend_nx    = 1'b0;
            end else begin
                w_pend_nx = (r_bit_cnt == c_cnt_last) && (r_state != HUNT);
                case (r_state)
                    HUNT: begin
                        if (w_sync) begin
                            // This edge already carries bit 0 of the next word
                            w_matches_nx = 4'd1;
                            w_bit_cnt_nx = 4'd1;
                            w_pend_nx    = 1'b0;
                            w_state_nx   = (c_sync_cnt == 4'd1) ? LOCKED : VERIFY;
                        end
                    end
                    VERIFY: begin
                        if (r_pend) begin
                            if (w_sync) begin
                                w_matches_nx = r_matches + 4'd1;
                                if ((r_matches + 4'd1) >= c_sync_cnt) begin
                                    w_state_nx = LOCKED;
                                end
                            end else begin
                                w_matches_nx = '0;
                                w_state_nx   = HUNT;
                            end
                        end
                    end
                    LOCKED: begin
                        if (r_pend) begin
                            w_ss_nx = w_sync;
                            if (!(DROP_SYNC && w_sync)) begin
                                w_load  = 1'b1;
                                w_dv_nx = 1'b1;
                            end
                        end
                    end
                    default: begin
                        w_state_nx   = HUNT;
                        w_matches_nx = '0;
                    end
                endcase
            end
        end
    end

    // Output registers: strobes last one cycle, data held between strobes
    always_ff @(posedge out_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data   <= '0;
            r_dv     <= 1'b0;
            r_locked <= 1'b0;
            r_ss     <= 1'b0;
        end else begin
            r_dv     <= w_dv_nx;
            r_ss     <= w_ss_nx;
            r_locked <= (w_state_nx == LOCKED);
            if (w_load) begin
                r_data <= w_sh;
            end
        end
    end

    assign dataOut   = r_data;
    assign dataV     = r_dv;
    assign locked    = r_locked;
    assign sync_seen = r_ss;

endmodule
`default_nettype wire

// File: tb/tb_big_deserialize.sv
`default_nettype none
// ============================================================================
// Module      : tb_big_deserialize
// Description : Self-checking bench for big_deserialize: a table of framed
//               words plus hand sequences for mismatch, resync and reset.
// Revision    : 1.0  initial release
// ============================================================================
module tb_big_deserialize;

    localparam logic [31:0] SYNC = 32'hBC5A_3C0F;

    logic        out_clk;
    logic        reset_n;
    logic        enable;
    logic        resync;
    logic        dataIn1;
    logic        dataIn2;
    logic [31:0] dataOut;
    logic        dataV;
    logic        locked;
    logic        sync_seen;

    big_deserialize dut (
        .out_clk   (out_clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .resync    (resync),
        .dataIn1   (dataIn1),
        .dataIn2   (dataIn2),
        .dataOut   (dataOut),
        .dataV     (dataV),
        .locked    (locked),
        .sync_seen (sync_seen)
    );

    initial out_clk = 1'b0;
    always #5 out_clk = ~out_clk;

    int nchk  = 0;
    int npass = 0;
    int cyc   = 0;
    bit en_q  = 1'b1;
    logic [31:0] last_data = '0;

    typedef struct {
        bit          is_ss;
        logic [31:0] word;
        int          cyc;
    } exp_t;
    exp_t q[$];

    typedef struct {
        bit          new_link;
        int          pre_bits;
        logic [31:0] word;
        int          pause_at;
        int          pause_len;
        bit          exp_dv;
        bit          exp_ss;
    } vec_t;
    vec_t tbl[7];

    always @(posedge out_clk) begin
        cyc  <= cyc + 1;
        en_q <= enable;
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Scoreboard: every strobe must match the oldest expectation
    always @(negedge out_clk) begin
        if (reset_n) begin
            if (!en_q) chk("strobe_while_disabled", {62'd0, dataV, sync_seen}, 64'd0);
            if (dataV || sync_seen) begin
                if (q.size() == 0) begin
                    chk("unexpected_strobe", {62'd0, dataV, sync_seen}, 64'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("strobe_dataV",     {63'd0, dataV},     {63'd0, !e.is_ss});
                    chk("strobe_sync_seen", {63'd0, sync_seen}, {63'd0, e.is_ss});
                    chk("strobe_cycle",     64'(cyc),           64'(e.cyc));
                    chk("strobe_dataOut",   {32'd0, dataOut},   {32'd0, e.word});
                end
            end
        end
    end

    // Serializer model: lane1 carries bits 31:16, lane2 bits 15:0, MSB first
    task automatic send_word(input logic [31:0] w, input int pause_at, input int pause_len,
                             input bit rs_last, input bit push_dv, input bit push_ss);
        for (int i = 0; i < 16; i++) begin
            @(negedge out_clk);
            if (i == pause_at) begin
                enable = 1'b0;
                repeat (pause_len) @(negedge out_clk);
                enable = 1'b1;
            end
            if (i == 15 && rs_last) resync = 1'b1;
            dataIn1 = w[31-i];
            dataIn2 = w[15-i];
            if (i == 15) begin
                // LSB edge is the next posedge; strobe visible after the one after
                if (push_dv) begin
                    q.push_back('{is_ss: 1'b0, word: w, cyc: cyc + 2});
                    last_data = w;
                end
                if (push_ss) q.push_back('{is_ss: 1'b1, word: last_data, cyc: cyc + 2});
            end
        end
    endtask

    task automatic rand_bits(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge out_clk);
            dataIn1 = 1'($urandom);
            dataIn2 = 1'($urandom);
        end
    endtask

    task automatic do_reset();
        repeat (3) @(negedge out_clk);
        reset_n   = 1'b0;
        enable    = 1'b1;
        resync    = 1'b0;
        last_data = '0;
        @(negedge out_clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1'b1, 0, 32'hDEADBEEF, 16, 0, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 5, 32'h12345678, 16, 0, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 0, 32'h0000FFFF, 16, 0, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 0, 32'hCAFEF00D,  8, 7, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 0, SYNC,         16, 0, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 0, 32'h00000000, 16, 0, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 0, 32'hFFFFFFFF, 16, 0, 1'b1, 1'b0};

        reset_n = 1'b0;
        enable  = 1'b1;
        resync  = 1'b0;
        dataIn1 = 1'b0;
        dataIn2 = 1'b0;

        // Reset held with random lane activity
        rand_bits(20);
        chk("reset_dataOut",   {32'd0, dataOut},   64'd0);
        chk("reset_dataV",     {63'd0, dataV},     64'd0);
        chk("reset_locked",    {63'd0, locked},    64'd0);
        chk("reset_sync_seen", {63'd0, sync_seen}, 64'd0);
        @(negedge out_clk);
        reset_n = 1'b1;

        // Table of framed words
        for (int k = 0; k < 7; k++) begin
            if (tbl[k].new_link) begin
                do_reset();
                rand_bits(tbl[k].pre_bits);
                send_word(SYNC, 16, 0, 1'b0, 1'b0, 1'b0);
                chk("locked_before_lock", {63'd0, locked}, 64'd0);
                send_word(SYNC, 16, 0, 1'b0, 1'b0, 1'b0);
            end
            send_word(tbl[k].word, tbl[k].pause_at, tbl[k].pause_len, 1'b0,
                      tbl[k].exp_dv, tbl[k].exp_ss);
            chk($sformatf("locked_vec%0d", k), {63'd0, locked}, 64'd1);
        end
        repeat (3) @(negedge out_clk);
        chk("queue_drained_table", 64'(q.size()), 64'd0);

        // One sync then a mismatch: back to hunting, no data
        do_reset();
        send_word(SYNC,         16, 0, 1'b0, 1'b0, 1'b0);
        send_word(32'hA5A5A5A5, 16, 0, 1'b0, 1'b0, 1'b0);
        send_word(32'h00000000, 16, 0, 1'b0, 1'b0, 1'b0);
        chk("locked_after_mismatch", {63'd0, locked}, 64'd0);
        send_word(SYNC,         16, 0, 1'b0, 1'b0, 1'b0);
        send_word(SYNC,         16, 0, 1'b0, 1'b0, 1'b0);
        send_word(32'h600DF00D, 16, 0, 1'b0, 1'b1, 1'b0);
        chk("locked_relock", {63'd0, locked}, 64'd1);

        // Sync word while locked, then resync at a word boundary
        send_word(SYNC,         16, 0, 1'b0, 1'b0, 1'b1);
        send_word(32'h13572468, 16, 0, 1'b1, 1'b0, 1'b0);
        @(negedge out_clk);
        chk("locked_after_resync", {63'd0, locked}, 64'd0);
        resync = 1'b0;
        repeat (3) @(negedge out_clk);
        chk("locked_stays_low", {63'd0, locked}, 64'd0);

        // Relock, then async reset mid-word
        send_word(SYNC,         16, 0, 1'b0, 1'b0, 1'b0);
        send_word(SYNC,         16, 0, 1'b0, 1'b0, 1'b0);
        send_word(32'h0F0F1234, 16, 0, 1'b0, 1'b1, 1'b0);
        repeat (3) @(negedge out_clk);
        chk("locked_before_reset", {63'd0, locked}, 64'd1);
        rand_bits(8);
        @(posedge out_clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_dataOut",   {32'd0, dataOut},   64'd0);
        chk("async_dataV",     {63'd0, dataV},     64'd0);
        chk("async_locked",    {63'd0, locked},    64'd0);
        chk("async_sync_seen", {63'd0, sync_seen}, 64'd0);
        @(negedge out_clk);
        reset_n = 1'b1;
        repeat (2) @(negedge out_clk);
        chk("queue_drained_end", 64'(q.size()), 64'd0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
`default_nettype wire
